// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: issues split-transaction SRAM fetches with up to DEPTH outstanding,
// buffers returned {pc, inst} pairs in order and drops responses from a redirected-away stream.
module inst_fetch_queue #(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic              clk,
    input  logic              resetn,
    output logic              inst_sram_req,
    output logic [ADDR_W-1:0] inst_sram_addr,
    input  logic              inst_sram_addr_ok,
    input  logic              inst_sram_data_ok,
    input  logic [DATA_W-1:0] inst_sram_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fs_valid,
    input  logic              fs_ready,
    output logic [ADDR_W-1:0] fs_pc,
    output logic [DATA_W-1:0] fs_inst
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));
    localparam logic [ADDR_W-1:0] RST_PC     = ADDR_W'(RESET_PC) & ALIGN_MASK;
    localparam logic [CW:0]       DEPTH_C    = (CW+1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] tag_mem_q [DEPTH];
    logic [ADDR_W-1:0] tag_mem_d [DEPTH];
    logic [PW-1:0]     tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [ADDR_W-1:0] pc_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_d [DEPTH];
    logic [DATA_W-1:0] inst_mem_q [DEPTH];
    logic [DATA_W-1:0] inst_mem_d [DEPTH];
    logic [PW-1:0]     q_wr_q, q_wr_d, q_rd_q, q_rd_d;
    logic [CW-1:0]     occ_q, occ_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     discard_q, discard_d;

    logic hs, rsp, keep, pop, credit_ok;

    // Credits cover both in-flight requests and queued entries, so a response always finds room.
    assign credit_ok      = ({1'b0, inflight_q} + {1'b0, occ_q}) < DEPTH_C;
    assign inst_sram_req  = resetn & ~redirect_valid & credit_ok;
    assign inst_sram_addr = fetch_pc_q;
    assign fs_valid       = (occ_q != '0);
    assign fs_pc          = pc_mem_q[q_rd_q];
    assign fs_inst        = inst_mem_q[q_rd_q];

    always_comb begin
        hs   = inst_sram_req & inst_sram_addr_ok;
        rsp  = inst_sram_data_ok & (inflight_q != '0);
        keep = rsp & ~redirect_valid & (discard_q == '0);
        pop  = fs_valid & fs_ready & ~redirect_valid;

        fetch_pc_d = fetch_pc_q;
        tag_mem_d  = tag_mem_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        q_wr_d     = q_wr_q;
        q_rd_d     = q_rd_q;
        discard_d  = discard_q;

        if (hs) begin
            tag_mem_d[tag_wr_q] = fetch_pc_q;
            tag_wr_d            = tag_wr_q + PW'(1);
            fetch_pc_d          = fetch_pc_q + ADDR_W'(4);
        end

        if (rsp) begin
            tag_rd_d = tag_rd_q + PW'(1);
            if (discard_q != '0) begin
                discard_d = discard_q - CW'(1);
            end
        end

        if (keep) begin
            pc_mem_d[q_wr_q]   = tag_mem_q[tag_rd_q];
            inst_mem_d[q_wr_q] = inst_sram_rdata;
            q_wr_d             = q_wr_q + PW'(1);
        end

        if (pop) begin
            q_rd_d = q_rd_q + PW'(1);
        end

        inflight_d = inflight_q + CW'(hs) - CW'(rsp);
        occ_d      = occ_q + CW'(keep) - CW'(pop);

        // Tag FIFO is not flushed: stale responses still arrive and must pop their tags.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ALIGN_MASK;
            discard_d  = inflight_q - CW'(rsp);
            q_rd_d     = q_wr_q;
            occ_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc_q <= RST_PC;
            tag_mem_q  <= '{default: '0};
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            pc_mem_q   <= '{default: '0};
            inst_mem_q <= '{default: '0};
            q_wr_q     <= '0;
            q_rd_q     <= '0;
            occ_q      <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            tag_mem_q  <= tag_mem_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            pc_mem_q   <= pc_mem_d;
            inst_mem_q <= inst_mem_d;
            q_wr_q     <= q_wr_d;
            q_rd_q     <= q_rd_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue against a queue-based reference model and an SRAM model.
module tb_inst_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok = 1'b0;
    logic        inst_sram_data_ok = 1'b0;
    logic [31:0] inst_sram_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fs_valid;
    logic        fs_ready = 1'b0;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;

    inst_fetch_queue #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fs_valid(fs_valid), .fs_ready(fs_ready), .fs_pc(fs_pc), .fs_inst(fs_inst)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: architectural view with plain queues.
    logic [31:0] m_pc;
    logic [31:0] m_tag[$];
    logic [63:0] m_dq[$];
    int          m_disc;
    logic [31:0] s_data[$];   // SRAM side: data owed for accepted requests, in order

    bit          force_red = 1'b0;
    logic [31:0] force_pc  = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = RESET_PC;
        m_disc = 0;
        m_tag.delete();
        m_dq.delete();
        s_data.delete();
    endtask

    task automatic check_reset_outputs();
        chk("rst_req", {63'd0, inst_sram_req}, 64'd0);
        chk("rst_fs_valid", {63'd0, fs_valid}, 64'd0);
        chk("rst_fs_pc", {32'd0, fs_pc}, 64'd0);
        chk("rst_fs_inst", {32'd0, fs_inst}, 64'd0);
    endtask

    task automatic step(input int p_aok, input int p_dok, input int p_rdy, input int p_red);
        bit          exp_req, hs, rsp, pop;
        logic [31:0] tpc;
        @(negedge clk);
        inst_sram_addr_ok = ($urandom_range(99) < p_aok);
        if (s_data.size() > 0) begin
            inst_sram_data_ok = ($urandom_range(99) < p_dok);
            inst_sram_rdata   = inst_sram_data_ok ? s_data[0] : $urandom;
        end else begin
            inst_sram_data_ok = ($urandom_range(99) < 2);
            inst_sram_rdata   = $urandom;
        end
        fs_ready       = ($urandom_range(99) < p_rdy);
        redirect_valid = force_red || ($urandom_range(99) < p_red);
        if (force_red)                     redirect_pc = force_pc;
        else if ($urandom_range(3) == 0)   redirect_pc = 32'hfffffff0 + $urandom_range(15);
        else                               redirect_pc = $urandom;
        #1;
        exp_req = !redirect_valid && ((m_tag.size() + m_dq.size()) < DEPTH);
        chk("req", {63'd0, inst_sram_req}, {63'd0, exp_req});
        if (exp_req) chk("addr", {32'd0, inst_sram_addr}, {32'd0, m_pc});
        chk("fs_valid", {63'd0, fs_valid}, {63'd0, m_dq.size() != 0});
        if (m_dq.size() != 0) begin
            chk("fs_pc", {32'd0, fs_pc}, {32'd0, m_dq[0][63:32]});
            chk("fs_inst", {32'd0, fs_inst}, {32'd0, m_dq[0][31:0]});
        end

        hs  = exp_req && inst_sram_addr_ok;
        rsp = inst_sram_data_ok && (m_tag.size() > 0);
        pop = (m_dq.size() > 0) && fs_ready && !redirect_valid;
        if (pop) m_dq.delete(0);
        if (rsp) begin
            tpc = m_tag.pop_front();
            if (m_disc > 0)           m_disc--;
            else if (!redirect_valid) m_dq.push_back({tpc, inst_sram_rdata});
        end
        if (redirect_valid) begin
            m_dq.delete();
            m_disc = m_tag.size();
            m_pc   = redirect_pc & ~32'd3;
        end else if (hs) begin
            m_tag.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end

        if (inst_sram_data_ok && s_data.size() > 0) s_data.delete(0);
        if (hs) s_data.push_back($urandom);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 resetn = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 check_reset_outputs();
        release_reset();

        // Streaming with everything ready: one instruction per cycle.
        repeat (20) step(100, 100, 100, 0);

        // Decode stalled: credits exhausted, then one pop frees a slot.
        repeat (10) step(100, 100, 0, 0);
        step(100, 100, 100, 0);
        repeat (4) step(100, 100, 0, 0);

        // Redirect with requests in flight, then near the top of the address space.
        force_red = 1'b1; force_pc = 32'h1c000103;
        step(100, 0, 100, 0);
        force_red = 1'b0;
        repeat (10) step(100, 60, 100, 0);
        force_red = 1'b1; force_pc = 32'hfffffffb;
        step(100, 100, 100, 0);
        force_red = 1'b0;
        repeat (12) step(100, 100, 100, 0);

        repeat (1500) step(60, 50, 60, 5);

        // Fill the queue, then assert reset asynchronously between edges.
        repeat (8) step(100, 100, 0, 0);
        #2 resetn = 1'b0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        redirect_valid    = 1'b0;
        #1 check_reset_outputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_reset_outputs();
        release_reset();

        repeat (8) step(100, 100, 100, 0);
        repeat (1500) step(70, 40, 50, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Parametrised instruction-fetch front end, the successor to the single-cycle PC/fetch logic. It replaces the zero-latency instruction SRAM with a split-transaction SRAM-like interface and supports multiple outstanding requests. Fetched {pc, inst} pairs are buffered in a DEPTH-entry in-order queue. Responses belonging to a redirected-away stream are discarded. It sits between the instruction SRAM port and the decode stage.

## Interface
- ADDR_W, 32, PC and SRAM address width.
- DATA_W, 32, instruction width.
- DEPTH, 4, queue entries and maximum in-flight requests; power of two, ≥2.
- RESET_PC, 32'h1c000000, first fetch address after reset, truncated to ADDR_W.

Ports:
- clk  in  1  clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- inst_sram_req  out  1  fetch request.
- inst_sram_addr  out  ADDR_W  fetch address; low 2 bits always 0.
- inst_sram_addr_ok  in  1  address accepted when sampled with req=1.
- inst_sram_data_ok  in  1  one response returns, in request order.
- inst_sram_rdata  in  DATA_W  response data, valid with data_ok.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_W  restart address; low 2 bits ignored and forced to 0.
- fs_valid  out  1  queue head valid.
- fs_ready  in  1  decode accepts the head.
- fs_pc  out  ADDR_W  head PC.
- fs_inst  out  DATA_W  head instruction.

## Operation
- State:
  - fetch_pc.
  - tag FIFO of accepted-request PCs, DEPTH entries.
  - data queue of {pc, inst}, DEPTH entries, with occupancy occ.
  - inflight: accepted requests whose data has not yet returned, 0..DEPTH.
  - discard: count of pending responses to drop, 0..DEPTH.
- Request:
  - inst_sram_req = resetn & ~redirect_valid & (inflight + occ < DEPTH).
  - inst_sram_addr = fetch_pc.
- Address handshake (req & addr_ok):
  - Push fetch_pc onto the tag FIFO.
  - fetch_pc += 4, modulo 2^ADDR_W (wraps to 0).
  - inflight increments.
- Response (data_ok):
  - Pop the tag FIFO; inflight decrements.
  - If discard≠0: drop the data and decrement discard.
  - Otherwise write {tag, rdata} to the data queue tail.
  - data_ok with inflight=0 is a protocol violation; ignore it with no state change.
- Pop (fs_valid & fs_ready): remove the head.
- fs_valid = (occ≠0). fs_pc and fs_inst come from head storage with no combinational path from rdata.
- Redirect (redirect_valid=1), all effective at the next edge:
  - Empty the data queue; any pop this cycle is void.
  - fetch_pc ← redirect_pc & ~3.
  - discard ← inflight − data_ok (all still-pending responses are stale).
  - A data_ok arriving in the redirect cycle is also dropped.
  - req is low in the redirect cycle, so no new address is accepted in it.
- Simultaneous handshake, response and pop in one cycle: all three take effect, and the counters net correctly.
- The credit rule guarantees that a response never finds the data queue full.

## Timing
- Async reset: asserting resetn=0 clears state immediately, regardless of clk. While in reset:
  - fetch_pc=RESET_PC; occ=inflight=discard=0.
  - queue storage is 0, so fs_valid=0, fs_pc=0, fs_inst=0.
  - inst_sram_req=0.
- Reset asserted mid-operation abandons all in-flight requests without discard. The SRAM side must reset together with this block.
- First cycle after resetn deasserts: req=1 with addr=RESET_PC.
- Latency:
  - data_ok in cycle N → fs_valid=1 in cycle N+1.
  - Minimum addr_ok to fs_valid is 2 cycles with a 1-cycle SRAM.
- Throughput: one instruction per cycle when addr_ok and data_ok are held high and fs_ready=1.
- addr may change while req=1 and addr_ok=0 only on redirect. The SRAM samples address on addr_ok only.
- Credit released by a pop or a discarded response in cycle N allows req in cycle N+1.

## Test plan
- Reset, addr_ok=1, data_ok one cycle after each accept, fs_ready=1 → addrs 0x1c000000, 0x1c000004, 0x1c000008; fs_pc follows the same sequence with matching fs_inst, one per cycle after 2-cycle fill.
- fs_ready=0, DEPTH=4 → exactly 4 address handshakes, then req=0 while occ=4. Raise fs_ready for one cycle → req=1 the next cycle, addr=0x1c000010.
- Two requests in flight (0x1c000000 and 0x1c000004 accepted, data pending), redirect_pc=0x1c000103 → next addr=0x1c000100. Both old responses are dropped; first fs_pc=0x1c000100.
- Redirect in the same cycle as data_ok for 0x1c000000, with one more request in flight → that data and the following response are both dropped; queue empty; discard reaches 0 after the second data_ok.
- RESET_PC=0xfffffff8, ADDR_W=32 → addrs 0xfffffff8, 0xfffffffc, 0x00000000.
- resetn=0 asynchronously mid-stream with occ=3 and inflight=1 → fs_valid=0 and req=0 before the next edge. After release: addr=RESET_PC, counters 0.
